tick_sprite_mover: RTL
======================

# tick_sprite_mover

Consumer of the slow toggle produced by the frame-rate clock divider. Synchronises that toggle into the system clock domain, turns each rising edge into a one-cycle update tick, and steps a rectangular sprite across the visible area, bouncing off the edges. Its `xpos`/`ypos` outputs feed the VGA draw stage as the top-left corner of the sprite.

## Interface

**Parameters**
- `X_MAX`, 800: visible width in pixels.
- `Y_MAX`, 600: visible height in pixels.
- `W`, 64: sprite width.
- `H`, 64: sprite height.
- `STEP_X`, 4: horizontal pixels per tick, must be at least 1.
- `STEP_Y`, 2: vertical pixels per tick, must be at least 1.
- `X0`, 0: start x.
- `Y0`, 0: start y.

**Ports**
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `tick_in`  in  1  slow toggle from the divider; asynchronous to use, so it is always synchronised.
- `start`  in  1  level; begin motion from IDLE.
- `pause`  in  1  level; freeze motion while high.
- `stop`  in  1  level; return to IDLE and the start position.
- `xpos`  out  12  sprite left edge.
- `ypos`  out  12  sprite top edge.
- `moving`  out  1  high in RUN.
- `bounce_x`  out  1  one-cycle pulse on a horizontal reversal.
- `bounce_y`  out  1  one-cycle pulse on a vertical reversal.

## Operation

- **Synchroniser.** Two flops `s1`, `s2`, plus a history flop `s3`. `tick = s2 & ~s3`. Only rising edges count; falling edges are ignored.
- **States.** IDLE, RUN, PAUSE.
- **State transitions.**
  - `stop` high in any state: go to IDLE and load `xpos=X0`, `ypos=Y0`, `dx=+`, `dy=+`. This has priority over everything else.
  - IDLE, `start` high: go to RUN, even if `pause` is also high. The pause takes effect on the next cycle.
  - RUN, `pause` high: go to PAUSE.
  - PAUSE, `pause` low: go to RUN.
- **Motion.** Position updates only in RUN and only on a `tick` cycle. Ticks arriving in IDLE or PAUSE are discarded, not queued.
- **X step.** Compute in 13-bit unsigned.
  - `dx=+`: if `xpos+STEP_X >= X_MAX-W`, then `xpos <= X_MAX-W`, `dx <= -`, and pulse `bounce_x`. Otherwise `xpos += STEP_X`.
  - `dx=-`: if `xpos <= STEP_X`, then `xpos <= 0`, `dx <= +`, and pulse `bounce_x`. Otherwise `xpos -= STEP_X`.
  - Landing exactly on a limit counts as a bounce.
- **Y step.** Identical to the X step, using `Y_MAX-H`, `STEP_Y`, `dy` and `bounce_y`.
- **Corner hits.** X and Y are independent. A corner hit pulses `bounce_x` and `bounce_y` in the same cycle.

## Timing

**Reset values**
- State IDLE.
- `xpos=X0`, `ypos=Y0`.
- `dx=+`, `dy=+`.
- `s1=s2=s3=0`.
- `moving=0`, `bounce_x=0`, `bounce_y=0`.

**Latency**
- `tick_in` rises and is captured by `s1` at edge N. `xpos`/`ypos` take their new value at edge N+2.
- `bounce_*` are registered and high only for the cycle after edge N+2.

**Outputs and state changes**
- `moving` is registered and equals (state==RUN). It changes one edge after the state-transition condition is sampled.
- All outputs are registered. There is no combinational path from input to output.

**Boundary cases**
- Reset asserted mid-motion: all registers clear immediately (asynchronous). The first tick after release produces no motion until `start`.
- `tick` in the same cycle as `pause` rising, while in RUN: the update is suppressed. The pause decision is made on the same edge as the step.
- `tick` in the same cycle as `start`, while in IDLE: no motion. The first step happens on the next tick.
- The toggle period is much longer than 3 clocks, so successive ticks never merge.

## Structure

- Package `sprite_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, PAUSE} mover_state_t`
  - `localparam POS_W = 12`
- Sub-module `edge_sync`: 2-flop synchroniser plus rising-edge detector.
  - Ports `clk`, `rst`, `d`, `rise`.
  - Reusable for button inputs.
- Top-level body: state register, direction flags, and the X and Y step logic.

## Test plan

All scenarios use the default parameters.

1. **Reset.** Hold `rst=0` for 5 clocks with `tick_in` toggling → `xpos=0`, `ypos=0`, `moving=0`, no bounce pulses.
2. **Basic steps.** `start` pulse, then 3 `tick_in` rises → `xpos` 4, 8, 12 and `ypos` 2, 4, 6. Each update lands exactly 2 clocks after the `s1` capture edge.
3. **Right-edge bounce.** Run from x=732 → next tick gives `xpos=736` with `bounce_x` high for 1 cycle and `dx=-`. The following tick gives 732.
4. **Pause and drop.** In RUN at x=100, raise `pause`, send 5 ticks, lower `pause` → `xpos` still 100. The next tick gives 104.
5. **Corner.** Preload so that the next tick hits x=736 and y=536 together → `bounce_x` and `bounce_y` pulse in the same cycle; both directions invert.
6. **Stop and async reset.** Assert `stop` at x=300 → IDLE, `xpos=0`, `moving=0`. Then drop `rst` asynchronously mid-cycle during RUN → outputs clear before the next clock edge.

Source files
------------

// File: rtl/tick_sprite_mover_pkg.sv
// Shared types and the per-axis bounce step for the sprite mover.
package sprite_pkg;

  localparam int POS_W = 12;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} mover_state_t;
  typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_t;

  typedef struct packed {
    logic [POS_W-1:0] pos;
    dir_t             dir;
    logic             hit;
  } axis_t;

  // One step along an axis. The sum is one bit wider than the position
  // so that pos+step cannot wrap before it is compared with the limit.
  function automatic axis_t axis_step(input logic [POS_W-1:0] pos,
                                      input dir_t             dir,
                                      input logic [POS_W:0]   step,
                                      input logic [POS_W:0]   lim);
    axis_t          r;
    logic [POS_W:0] p;
    p     = {1'b0, pos};
    r.pos = pos;
    r.dir = dir;
    r.hit = 1'b0;
    if (dir == DIR_POS) begin
      if (p + step >= lim) begin
        r.pos = lim[POS_W-1:0];
        r.dir = DIR_NEG;
        r.hit = 1'b1;
      end else begin
        r.pos = POS_W'(p + step);
      end
    end else begin
      if (p <= step) begin
        r.pos = '0;
        r.dir = DIR_POS;
        r.hit = 1'b1;
      end else begin
        r.pos = POS_W'(p - step);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_sprite_mover_if.sv
// Control inputs and position outputs of the sprite mover.
interface tick_sprite_mover_if;
  import sprite_pkg::*;

  logic             tick_in;
  logic             start;
  logic             pause;
  logic             stop;
  logic [POS_W-1:0] xpos;
  logic [POS_W-1:0] ypos;
  logic             moving;
  logic             bounce_x;
  logic             bounce_y;

  modport master (
    output tick_in, start, pause, stop,
    input  xpos, ypos, moving, bounce_x, bounce_y
  );

  modport slave (
    input  tick_in, start, pause, stop,
    output xpos, ypos, moving, bounce_x, bounce_y
  );
endinterface

// File: rtl/tick_sprite_mover_edge_sync.sv
// Two-flop synchroniser with a history flop; rise is high for one cycle
// after each synchronised low-to-high transition.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
endmodule

// File: rtl/tick_sprite_mover.sv
// Steps a sprite across the visible area on each divider tick, bouncing
// off the edges. xpos/ypos are the sprite's top-left corner.
module tick_sprite_mover
  import sprite_pkg::*;
#(
  parameter int X_MAX  = 800,
  parameter int Y_MAX  = 600,
  parameter int W      = 64,
  parameter int H      = 64,
  parameter int STEP_X = 4,
  parameter int STEP_Y = 2,
  parameter int X0     = 0,
  parameter int Y0     = 0
) (
  input logic               clk,
  input logic               rst,
  tick_sprite_mover_if.slave bus
);
  localparam logic [POS_W:0]   LIM_X  = (POS_W+1)'(X_MAX - W);
  localparam logic [POS_W:0]   LIM_Y  = (POS_W+1)'(Y_MAX - H);
  localparam logic [POS_W:0]   STP_X  = (POS_W+1)'(STEP_X);
  localparam logic [POS_W:0]   STP_Y  = (POS_W+1)'(STEP_Y);
  localparam logic [POS_W-1:0] X0_P   = POS_W'(X0);
  localparam logic [POS_W-1:0] Y0_P   = POS_W'(Y0);

  mover_state_t     state;
  logic [POS_W-1:0] xpos, ypos;
  dir_t             dx, dy;
  logic             moving, bounce_x, bounce_y;
  logic             tick;
  axis_t            nx, ny;

  edge_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.tick_in),
    .rise (tick)
  );

  always_comb begin
    nx = axis_step(xpos, dx, STP_X, LIM_X);
    ny = axis_step(ypos, dy, STP_Y, LIM_Y);
  end

  // A pause sampled on a tick edge wins: the step is dropped, not deferred.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      xpos     <= X0_P;
      ypos     <= Y0_P;
      dx       <= DIR_POS;
      dy       <= DIR_POS;
      moving   <= 1'b0;
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
    end else begin
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
      if (bus.stop) begin
        state  <= IDLE;
        xpos   <= X0_P;
        ypos   <= Y0_P;
        dx     <= DIR_POS;
        dy     <= DIR_POS;
        moving <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state  <= RUN;
              moving <= 1'b1;
            end
          end
          RUN: begin
            if (bus.pause) begin
              state  <= PAUSE;
              moving <= 1'b0;
            end else if (tick) begin
              xpos     <= nx.pos;
              dx       <= nx.dir;
              bounce_x <= nx.hit;
              ypos     <= ny.pos;
              dy       <= ny.dir;
              bounce_y <= ny.hit;
            end
          end
          PAUSE: begin
            if (!bus.pause) begin
              state  <= RUN;
              moving <= 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            moving <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.xpos     = xpos;
  assign bus.ypos     = ypos;
  assign bus.moving   = moving;
  assign bus.bounce_x = bounce_x;
  assign bus.bounce_y = bounce_y;
endmodule
